// File: rtl/pulse_seq_pkg.sv
// Shared types and defaults for the x1-x2-x2 pulse-mode sequence detector.
package pulse_seq_pkg;

  typedef enum logic [1:0] {
    StA = 2'b00,
    StB = 2'b01,
    StC = 2'b10,
    StD = 2'b11
  } state_e;

  localparam int unsigned DebounceCycDefault = 2_000_000;
  localparam int unsigned CntWDefault        = 4;

  // An x1 pulse always restarts the sequence; x2 advances it, and wraps back to idle from D.
  function automatic state_e next_state(state_e cur, logic p_x1, logic p_x2);
    state_e nxt;
    nxt = cur;
    if (p_x1) begin
      nxt = StB;
    end else if (p_x2) begin
      case (cur)
        StA:     nxt = StA;
        StB:     nxt = StC;
        StC:     nxt = StD;
        default: nxt = StA;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, debounce counter and registered rising-edge request.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic req_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            level_dly_q;
  logic            req_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(DEBOUNCE_CYC - 1)) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      req_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      // Only a press produces a request; releases are silent.
      req_q       <= level_q & ~level_dly_q;
      cnt_q       <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign req_o   = req_q;

endmodule

// File: rtl/pulse_seq_ctrl.sv
// Pulse-mode x1-x2-x2 detector: button conditioning, single-pulse arbitration, FSM and counter.
module pulse_seq_ctrl
  import pulse_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DebounceCycDefault,
  parameter int unsigned CNT_W        = CntWDefault
) (
  input  logic             cp,
  input  logic             rst_n,
  input  logic             btn_x1,
  input  logic             btn_x2,
  output logic [1:0]       state,
  output logic             z,
  output logic [CNT_W-1:0] det_cnt,
  output logic             busy,
  output logic             err
);

  logic lvl_x1, lvl_x2;
  logic req_x1, req_x2;
  logic p_x1, p_x2;
  logic discard;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_deb_x1 (
    .clk_i  (cp),
    .rst_ni (rst_n),
    .btn_i  (btn_x1),
    .level_o(lvl_x1),
    .req_o  (req_x1)
  );

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_deb_x2 (
    .clk_i  (cp),
    .rst_ni (rst_n),
    .btn_i  (btn_x2),
    .level_o(lvl_x2),
    .req_o  (req_x2)
  );

  // A request is only honoured while the other button is fully released.
  always_comb begin
    p_x1    = req_x1 & ~req_x2 & ~lvl_x2;
    p_x2    = req_x2 & ~req_x1 & ~lvl_x1;
    discard = (req_x1 | req_x2) & ~p_x1 & ~p_x2;
  end

  always_comb begin
    state_d = next_state(state_q, p_x1, p_x2);
    cnt_d   = cnt_q;
    err_d   = discard;
    if (p_x2 && (state_q == StC)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StA;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign state   = state_q;
  assign z       = (state_q == StD);
  assign det_cnt = cnt_q;
  assign busy    = lvl_x1 | lvl_x2;
  assign err     = err_q;

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Directed bench for pulse_seq_ctrl with a short debounce window.
module tb_pulse_seq_ctrl;

  localparam int unsigned Dc = 4;
  localparam int unsigned Cw = 4;

  logic          cp = 1'b0;
  logic          rst_n;
  logic          btn_x1, btn_x2;
  logic [1:0]    state;
  logic          z;
  logic [Cw-1:0] det_cnt;
  logic          busy;
  logic          err;

  int total = 0;
  int bad   = 0;
  int err_seen  = 0;
  int busy_seen = 0;

  typedef struct packed {
    logic          is_x1;
    logic [1:0]    st;
    logic          z;
    logic [Cw-1:0] cnt;
  } vec_t;

  vec_t tbl [9];

  pulse_seq_ctrl #(
    .DEBOUNCE_CYC(Dc),
    .CNT_W       (Cw)
  ) dut (
    .cp     (cp),
    .rst_n  (rst_n),
    .btn_x1 (btn_x1),
    .btn_x2 (btn_x2),
    .state  (state),
    .z      (z),
    .det_cnt(det_cnt),
    .busy   (busy),
    .err    (err)
  );

  always #5 cp = ~cp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hold the buttons for n cycles, sampling err/busy on each falling edge.
  task automatic drive(input logic b1, input logic b2, input int n);
    btn_x1 = b1;
    btn_x2 = b2;
    repeat (n) begin
      @(negedge cp);
      err_seen  += int'(err);
      busy_seen += int'(busy);
    end
  endtask

  task automatic press(input logic is_x1);
    drive(is_x1, ~is_x1, 12);
    drive(1'b0, 1'b0, 12);
  endtask

  task automatic do_reset();
    btn_x1 = 1'b0;
    btn_x2 = 1'b0;
    rst_n  = 1'b0;
    @(negedge cp);
    @(negedge cp);
    rst_n = 1'b1;
    @(negedge cp);
  endtask

  initial begin
    tbl[0] = '{is_x1: 1'b0, st: 2'b00, z: 1'b0, cnt: 4'd0};
    tbl[1] = '{is_x1: 1'b1, st: 2'b01, z: 1'b0, cnt: 4'd0};
    tbl[2] = '{is_x1: 1'b0, st: 2'b10, z: 1'b0, cnt: 4'd0};
    tbl[3] = '{is_x1: 1'b0, st: 2'b11, z: 1'b1, cnt: 4'd1};
    tbl[4] = '{is_x1: 1'b0, st: 2'b00, z: 1'b0, cnt: 4'd1};
    tbl[5] = '{is_x1: 1'b1, st: 2'b01, z: 1'b0, cnt: 4'd1};
    tbl[6] = '{is_x1: 1'b0, st: 2'b10, z: 1'b0, cnt: 4'd1};
    tbl[7] = '{is_x1: 1'b1, st: 2'b01, z: 1'b0, cnt: 4'd1};
    tbl[8] = '{is_x1: 1'b1, st: 2'b01, z: 1'b0, cnt: 4'd1};

    do_reset();
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_z", 32'(z), 32'd0);
    chk("reset_cnt", 32'(det_cnt), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err", 32'(err), 32'd0);

    // Exact latency of a clean x1 press: busy after edge 6, state after edge 8.
    drive(1'b1, 1'b0, 5);
    chk("lat_busy_early", 32'(busy), 32'd0);
    drive(1'b1, 1'b0, 1);
    chk("lat_busy_set", 32'(busy), 32'd1);
    drive(1'b1, 1'b0, 1);
    chk("lat_state_early", 32'(state), 32'd0);
    drive(1'b1, 1'b0, 1);
    chk("lat_state_set", 32'(state), 32'd1);
    drive(1'b1, 1'b0, 4);
    drive(1'b0, 1'b0, 12);
    chk("lat_busy_clear", 32'(busy), 32'd0);

    // Table of clean presses starting from idle.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      err_seen = 0;
      press(tbl[i].is_x1);
      chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_z", i), 32'(z), 32'(tbl[i].z));
      chk($sformatf("tbl%0d_cnt", i), 32'(det_cnt), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_err", i), 32'(err_seen), 32'd0);
    end

    // Short glitch on x1 never reaches the debounced level.
    err_seen  = 0;
    busy_seen = 0;
    drive(1'b1, 1'b0, 3);
    drive(1'b0, 1'b0, 12);
    chk("glitch_state", 32'(state), 32'd1);
    chk("glitch_err", 32'(err_seen), 32'd0);
    chk("glitch_busy", 32'(busy_seen), 32'd0);

    // Both buttons rise together: both requests dropped, one err pulse.
    do_reset();
    err_seen  = 0;
    busy_seen = 0;
    drive(1'b1, 1'b1, 12);
    chk("both_busy", 32'(busy), 32'd1);
    drive(1'b0, 1'b0, 12);
    chk("both_state", 32'(state), 32'd0);
    chk("both_err_cycles", 32'(err_seen), 32'd1);

    // x1 while x2 is held is rejected; afterwards x1 alone is accepted.
    do_reset();
    drive(1'b0, 1'b1, 12);
    err_seen = 0;
    drive(1'b1, 1'b1, 12);
    drive(1'b0, 1'b1, 12);
    chk("held_state", 32'(state), 32'd0);
    chk("held_err_cycles", 32'(err_seen), 32'd1);
    drive(1'b0, 1'b0, 12);
    err_seen = 0;
    press(1'b1);
    chk("held_after_state", 32'(state), 32'd1);
    chk("held_after_err", 32'(err_seen), 32'd0);

    // Sixteen complete sequences wrap the counter.
    do_reset();
    for (int s = 0; s < 16; s++) begin
      press(1'b1);
      press(1'b0);
      press(1'b0);
      if (s == 14) chk("wrap_cnt15", 32'(det_cnt), 32'd15);
    end
    chk("wrap_cnt0", 32'(det_cnt), 32'd0);
    chk("wrap_z", 32'(z), 32'd1);

    // Asynchronous reset mid-cycle while in C with a non-zero count.
    press(1'b1);
    press(1'b0);
    press(1'b0);
    press(1'b1);
    press(1'b0);
    chk("pre_rst_state", 32'(state), 32'd2);
    chk("pre_rst_cnt", 32'(det_cnt), 32'd1);
    @(posedge cp);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_z", 32'(z), 32'd0);
    chk("async_cnt", 32'(det_cnt), 32'd0);
    chk("async_err", 32'(err), 32'd0);
    @(negedge cp);
    rst_n = 1'b1;
    @(negedge cp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
